// File: rtl/timer_tick_multi_pkg.sv
// Shared types and constants for the multi-channel tick generator.
package timer_pkg;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   localparam logic        MODE_PERIODIC = 1'b0;
   localparam logic        MODE_ONESHOT  = 1'b1;
   localparam int unsigned DEF_PERIOD    = 2400;

   // Channel-index width; a single channel still gets a 1-bit index.
   function automatic int ld_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_tick_multi_if.sv
// Control/status bundle between the tick generator and its client logic.
interface timer_tick_multi_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 16
);
   import timer_pkg::*;

   localparam int LD_W = ld_width(NCH);

   logic [NCH-1:0]   start;
   logic [NCH-1:0]   stop;
   logic             ld_en;
   logic [LD_W-1:0]  ld_ch;
   logic [CNT_W-1:0] ld_period;
   logic             ld_oneshot;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   busy;

   modport master (
      output start, stop, ld_en, ld_ch, ld_period, ld_oneshot,
      input  tick, busy
   );

   modport slave (
      input  start, stop, ld_en, ld_ch, ld_period, ld_oneshot,
      output tick, busy
   );

endinterface

// File: rtl/timer_tick_multi_chan.sv
// One tick channel: shadow/active period and mode, counter, IDLE/RUN state.
module timer_tick_chan
   import timer_pkg::*;
#(
   parameter int          CNT_W      = 16,
   parameter int unsigned DEF_PERIOD = timer_pkg::DEF_PERIOD
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             ld_en,
   input  logic [CNT_W-1:0] ld_period,
   input  logic             ld_oneshot,
   output logic             tick,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
   logic [CNT_W-1:0] active_period_q, active_period_d;
   logic             shadow_mode_q, shadow_mode_d;
   logic             active_mode_q, active_mode_d;
   logic             tick_q, tick_d;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      shadow_period_d = ld_en ? ld_period  : shadow_period_q;
      shadow_mode_d   = ld_en ? ld_oneshot : shadow_mode_q;
      active_period_d = active_period_q;
      active_mode_d   = active_mode_q;
      state_d         = state_q;
      cnt_d           = cnt_q;
      tick_d          = 1'b0;

      // Copies take the _d shadow so a load in the same cycle is picked up.
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d         = ST_RUN;
               active_period_d = shadow_period_d;
               active_mode_d   = shadow_mode_d;
            end
         end
         ST_RUN: begin
            if (start) begin
               cnt_d           = '0;
               active_period_d = shadow_period_d;
               active_mode_d   = shadow_mode_d;
            end else if (stop) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == active_period_q) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               if (active_mode_q == MODE_ONESHOT) begin
                  state_d = ST_IDLE;
               end else begin
                  active_period_d = shadow_period_d;
                  active_mode_d   = shadow_mode_d;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         shadow_period_q <= CNT_W'(DEF_PERIOD);
         active_period_q <= CNT_W'(DEF_PERIOD);
         shadow_mode_q   <= MODE_PERIODIC;
         active_mode_q   <= MODE_PERIODIC;
         tick_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         shadow_period_q <= shadow_period_d;
         active_period_q <= active_period_d;
         shadow_mode_q   <= shadow_mode_d;
         active_mode_q   <= active_mode_d;
         tick_q          <= tick_d;
      end
   end

   assign tick = tick_q;
   assign busy = (state_q == ST_RUN);

endmodule

// File: rtl/timer_tick_multi.sv
// Multi-channel programmable tick generator: NCH independent channels plus load decode.
module timer_tick_multi #(
   parameter int          CNT_W      = 16,
   parameter int          NCH        = 4,
   parameter int unsigned DEF_PERIOD = timer_pkg::DEF_PERIOD
) (
   input  logic               clk_in,
   input  logic               reset,
   timer_tick_multi_if.slave  bus
);
   import timer_pkg::*;

   localparam int LD_W = ld_width(NCH);

   logic [NCH-1:0] tick_v;
   logic [NCH-1:0] busy_v;

   // Indices at or above NCH match no channel, so such loads are dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic ld_hit;
      assign ld_hit = bus.ld_en && (bus.ld_ch == LD_W'(i));

      timer_tick_chan #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_chan (
         .clk_in     (clk_in),
         .reset      (reset),
         .start      (bus.start[i]),
         .stop       (bus.stop[i]),
         .ld_en      (ld_hit),
         .ld_period  (bus.ld_period),
         .ld_oneshot (bus.ld_oneshot),
         .tick       (tick_v[i]),
         .busy       (busy_v[i])
      );
   end

   assign bus.tick = tick_v;
   assign bus.busy = busy_v;

endmodule

// File: tb/tb_timer_tick_multi.sv
// Directed self-checking bench for timer_tick_multi (4-channel main DUT, 3-channel DUT for range checks).
module tb_timer_tick_multi;

   logic clk_in = 1'b0;
   logic reset  = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_in = ~clk_in;

   timer_tick_multi_if #(.NCH(4), .CNT_W(16)) bus ();
   timer_tick_multi_if #(.NCH(3), .CNT_W(16)) bus3 ();

   timer_tick_multi #(.CNT_W(16), .NCH(4), .DEF_PERIOD(2400)) u_dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   timer_tick_multi #(.CNT_W(16), .NCH(3), .DEF_PERIOD(2400)) u_dut3 (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input int ch, input logic [15:0] p, input logic os);
      bus.ld_en      = 1'b1;
      bus.ld_ch      = 2'(ch);
      bus.ld_period  = p;
      bus.ld_oneshot = os;
      step();
      bus.ld_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] m);
      bus.start = m;
      step();
      bus.start = '0;
   endtask

   task automatic pulse_stop(input logic [3:0] m);
      bus.stop = m;
      step();
      bus.stop = '0;
   endtask

   initial begin
      int ticks;
      logic [2:0] tick_or;

      bus.start = '0;  bus.stop = '0;  bus.ld_en = 1'b0;
      bus.ld_ch = '0;  bus.ld_period = '0;  bus.ld_oneshot = 1'b0;
      bus3.start = '0; bus3.stop = '0; bus3.ld_en = 1'b0;
      bus3.ld_ch = '0; bus3.ld_period = '0; bus3.ld_oneshot = 1'b0;

      // Reset state
      steps(3);
      check("rst_tick", 32'(bus.tick), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      reset = 1'b1;
      step();

      // ch0 default period 2400, periodic
      pulse_start(4'b0001);
      check("c0_busy_start", 32'(bus.busy[0]), 32'h1);
      steps(2400);
      check("c0_pre_tick1", 32'(bus.tick[0]), 32'h0);
      step();
      check("c0_tick1", 32'(bus.tick[0]), 32'h1);
      step();
      check("c0_tick1_width", 32'(bus.tick[0]), 32'h0);
      steps(2399);
      check("c0_pre_tick2", 32'(bus.tick[0]), 32'h0);
      step();
      check("c0_tick2", 32'(bus.tick[0]), 32'h1);
      check("c0_busy_run", 32'(bus.busy[0]), 32'h1);
      pulse_stop(4'b0001);
      check("c0_stop_busy", 32'(bus.busy[0]), 32'h0);

      // ch1 one-shot P=3
      load(1, 16'd3, 1'b1);
      pulse_start(4'b0010);
      check("c1_busy", 32'(bus.busy[1]), 32'h1);
      steps(3);
      check("c1_pre_tick", 32'(bus.tick[1]), 32'h0);
      step();
      check("c1_tick", 32'(bus.tick[1]), 32'h1);
      check("c1_busy_fall", 32'(bus.busy[1]), 32'h0);
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         ticks += int'(bus.tick[1]);
      end
      check("c1_no_more_ticks", 32'(ticks), 32'h0);
      check("c1_idle", 32'(bus.busy[1]), 32'h0);

      // ch2 periodic P=9, reload P=4 mid-period
      load(2, 16'd9, 1'b0);
      pulse_start(4'b0100);
      steps(5);
      load(2, 16'd4, 1'b0);
      steps(3);
      check("c2_pre_tick_old", 32'(bus.tick[2]), 32'h0);
      step();
      check("c2_tick_old_p", 32'(bus.tick[2]), 32'h1);
      steps(4);
      check("c2_pre_tick_new", 32'(bus.tick[2]), 32'h0);
      step();
      check("c2_tick_new_p", 32'(bus.tick[2]), 32'h1);
      steps(5);
      check("c2_tick_new_p2", 32'(bus.tick[2]), 32'h1);
      // Load in the same cycle as a restart is taken immediately
      bus.ld_en = 1'b1; bus.ld_ch = 2'd2; bus.ld_period = 16'd2; bus.ld_oneshot = 1'b0;
      bus.start = 4'b0100;
      step();
      bus.ld_en = 1'b0; bus.start = '0;
      steps(2);
      check("c2_bypass_pre", 32'(bus.tick[2]), 32'h0);
      step();
      check("c2_bypass_tick", 32'(bus.tick[2]), 32'h1);
      pulse_stop(4'b0100);

      // ch3 P=7: start+stop together restarts; restart at terminal count; stop at terminal
      load(3, 16'd7, 1'b0);
      pulse_start(4'b1000);
      steps(5);
      bus.start = 4'b1000; bus.stop = 4'b1000;
      step();
      bus.start = '0; bus.stop = '0;
      check("c3_startstop_busy", 32'(bus.busy[3]), 32'h1);
      steps(7);
      check("c3_restart_pre", 32'(bus.tick[3]), 32'h0);
      step();
      check("c3_restart_tick", 32'(bus.tick[3]), 32'h1);
      steps(7);
      pulse_start(4'b1000);
      check("c3_restart_at_p_no_tick", 32'(bus.tick[3]), 32'h0);
      check("c3_restart_at_p_busy", 32'(bus.busy[3]), 32'h1);
      steps(7);
      pulse_stop(4'b1000);
      check("c3_stop_tick", 32'(bus.tick[3]), 32'h0);
      check("c3_stop_busy", 32'(bus.busy[3]), 32'h0);

      // P=0 periodic on ch0: tick every cycle
      load(0, 16'd0, 1'b0);
      pulse_start(4'b0001);
      ticks = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         ticks += int'(bus.tick[0]);
      end
      check("c0_p0_every_cycle", 32'(ticks), 32'd4);
      pulse_stop(4'b0001);
      check("c0_p0_stop", 32'(bus.tick[0]), 32'h0);

      // P=0 one-shot on ch1: exactly one tick
      load(1, 16'd0, 1'b1);
      pulse_start(4'b0010);
      step();
      check("c1_p0_os_tick", 32'(bus.tick[1]), 32'h1);
      check("c1_p0_os_busy", 32'(bus.busy[1]), 32'h0);
      step();
      check("c1_p0_os_single", 32'(bus.tick[1]), 32'h0);

      // Out-of-range load index on the 3-channel instance changes nothing
      bus3.ld_en = 1'b1; bus3.ld_ch = 2'd3; bus3.ld_period = 16'd1; bus3.ld_oneshot = 1'b0;
      step();
      bus3.ld_en = 1'b0;
      bus3.start = 3'b111;
      step();
      bus3.start = '0;
      check("oor_busy", 32'(bus3.busy), 32'h7);
      tick_or = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         tick_or |= bus3.tick;
      end
      check("oor_no_tick", 32'(tick_or), 32'h0);
      bus3.stop = 3'b111;
      step();
      bus3.stop = '0;

      // Reset while every channel sits at terminal count
      for (int c = 0; c < 4; c++) load(c, 16'd5, 1'b0);
      pulse_start(4'b1111);
      steps(5);
      reset = 1'b0;
      step();
      check("rst_mid_tick", 32'(bus.tick), 32'h0);
      check("rst_mid_busy", 32'(bus.busy), 32'h0);
      reset = 1'b1;
      pulse_start(4'b1111);
      steps(2400);
      check("rst_def_pre", 32'(bus.tick), 32'h0);
      step();
      check("rst_def_tick", 32'(bus.tick), 32'hf);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_tick_multi.md
# timer_tick_multi

Multi-channel programmable tick generator; parametrised successor of the fixed-period 0.25 s timer. Each of NCH channels owns a runtime-loadable period and a periodic/one-shot mode and emits single-cycle tick pulses on clk_in. Sits between the system clock domain and the UART/counter logic that needs several independent time bases.

## Interface
- CNT_W, 16, counter and period width in bits
- NCH, 4, number of independent channels (1..16)
- DEF_PERIOD, 2400, reset value of every channel's period register (tick every DEF_PERIOD+1 cycles)
- clk_in  input  1  sole clock, all logic on posedge
- reset  input  1  synchronous, active-low; sampled on posedge clk_in only
- start  input  NCH  per-channel one-cycle start/restart request
- stop  input  NCH  per-channel one-cycle stop request
- ld_en  input  1  load strobe for period/mode
- ld_ch  input  $clog2(NCH) (min 1)  channel index for load
- ld_period  input  CNT_W  new period value P
- ld_oneshot  input  1  new mode: 1 one-shot, 0 periodic
- tick  output  NCH  registered one-cycle pulse per channel
- busy  output  NCH  registered, high while channel in RUN

## Operation
- Per channel: shadow period/mode (written by load), active period/mode (used by counter), counter cnt, state IDLE/RUN.
- Load: ld_en high with ld_ch < NCH writes shadow of that channel; ld_ch >= NCH ignored. Never disturbs cnt or state.
- Shadow-to-active copy: on accepted start, and on every wrap in periodic mode. Load in the same cycle as start/wrap: the new load value is copied (bypass).
- IDLE: cnt holds 0, tick 0. start -> RUN, cnt <= 0.
- RUN: if cnt == active P: cnt <= 0, tick <= 1; periodic stays RUN; one-shot -> IDLE. Otherwise cnt <= cnt+1, tick <= 0.
- start in RUN: restart, cnt <= 0, no tick that cycle, even if cnt == P.
- stop: -> IDLE, cnt <= 0, tick <= 0; start and stop same cycle: start wins.
- P = 0: periodic ticks every cycle while RUN; one-shot produces exactly one tick.
- Counter width-limited to CNT_W; cnt never exceeds P so no wrap-around of cnt itself; P = 2^CNT_W-1 valid.
- Channels fully independent; no shared arithmetic.

## Timing
- reset low at a posedge: all channels IDLE, cnt 0, tick 0, busy 0, shadow/active period DEF_PERIOD, mode periodic. Reset mid-run aborts without tick.
- start accepted at edge k: busy high after edge k; first tick high during the cycle after edge k+P+1 (P+1 cycles after start); periodic ticks repeat every P+1 cycles.
- One-shot: busy falls on the same edge that raises tick.
- tick width exactly one cycle; never asserted in consecutive cycles unless P = 0.
- stop at edge k: tick and busy low after edge k.

## Structure
- Package timer_pkg: state enum {ST_IDLE, ST_RUN}, mode constants MODE_PERIODIC=0 / MODE_ONESHOT=1, DEF_PERIOD default.
- Sub-module timer_tick_chan: one channel (shadow/active regs, counter, FSM, tick/busy); top generates NCH instances and decodes ld_ch into per-channel load enables.

## Test plan
- Reset, start ch0 with default P=2400 periodic -> first tick 2401 cycles after start, then every 2401 cycles; busy stays 1.
- Load ch1 P=3 one-shot, start -> single tick 4 cycles after start, busy falls with tick, no further ticks for 100 cycles.
- ch2 periodic P=9 running, load P=4 mid-period -> current period still 10 cycles, subsequent periods 5 cycles.
- start and stop asserted same cycle on ch3 running at cnt=5 -> restart, next tick P+1 cycles later; stop alone -> tick/busy 0 next cycle.
- P=0 periodic -> tick high every cycle; ld_ch=NCH (out of range) -> no channel changes.
- reset pulled low while all channels RUN near terminal count -> no tick, all outputs 0, periods back to 2400.
